mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter onto a single
// word-wide memory port. Data wins over fetch; wide data accesses are split
// into two consecutive word accesses (low word at addr, high word at addr+1).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack)
//   if_rdata/if_ack          fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_wide     data request, write enable, two-word access
//   dm_addr/dm_wdata         data address (low word), write data
//   dm_rdata/dm_ack          read data (high half zero if narrow), completion
//   mem_req/mem_we/mem_addr/mem_wdata   memory request side (registered)
//   mem_rdata/mem_ack        memory response; ack may come with or after req
//
// Optional feature: define MEM_ARB_FAIRNESS_EN to force a fetch grant after
// MAX_DM_RUN back-to-back data grants made while a fetch was waiting.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MAX_DM_RUN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic                  dm_wide,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [2*DATA_W-1:0]   dm_wdata,
    output logic [2*DATA_W-1:0]   dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IF_RD = 3'd1,
        DM_LO = 3'd2,
        DM_HI = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                state_q;
    logic                  we_q;
    logic                  wide_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_hi_q;
    logic [DATA_W-1:0]     rd_lo_q;
    logic [DATA_W-1:0]     if_rdata_q;
    logic                  if_ack_q;
    logic [2*DATA_W-1:0]   dm_rdata_q;
    logic                  dm_ack_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic                  grant_dm_c;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int unsigned RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);

    logic [RUN_W-1:0] dm_run_q;
    logic             force_if_c;

    // A waiting fetch that has been passed over MAX_DM_RUN times wins next.
    assign force_if_c = if_req && (dm_run_q == RUN_W'(MAX_DM_RUN));
    assign grant_dm_c = dm_req && !force_if_c;

    // Counts data grants that starved a pending fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            dm_run_q <= '0;
        end else if (state_q == IDLE) begin
            if (grant_dm_c) begin
                dm_run_q <= if_req ? dm_run_q + RUN_W'(1) : '0;
            end else if (if_req) begin
                dm_run_q <= '0;
            end
        end
    end
`else
    logic unused_cfg;

    assign grant_dm_c = dm_req;
    assign unused_cfg = ^32'(MAX_DM_RUN);
`endif

    // Arbitration FSM; every memory-side and requester-side output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            wide_q      <= 1'b0;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            rd_lo_q     <= '0;
            if_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_rdata_q  <= '0;
            dm_ack_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_dm_c) begin
                        we_q        <= dm_we;
                        wide_q      <= dm_wide;
                        addr_q      <= dm_addr;
                        wdata_hi_q  <= dm_wdata[2*DATA_W-1:DATA_W];
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata[DATA_W-1:0];
                        state_q     <= DM_LO;
                    end else if (if_req) begin
                        we_q        <= 1'b0;
                        wide_q      <= 1'b0;
                        addr_q      <= if_addr;
                        wdata_hi_q  <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        state_q     <= IF_RD;
                    end
                end
                IF_RD: begin
                    if (mem_ack) begin
                        if_rdata_q <= mem_rdata;
                        if_ack_q   <= 1'b1;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DM_LO: begin
                    if (mem_ack) begin
                        if (wide_q) begin
                            // Low word is parked until the whole access completes.
                            if (!we_q) begin
                                rd_lo_q <= mem_rdata;
                            end
                            mem_addr_q  <= addr_q + ADDR_W'(1);
                            mem_wdata_q <= wdata_hi_q;
                            state_q     <= DM_HI;
                        end else begin
                            if (!we_q) begin
                                dm_rdata_q <= {DATA_W'(0), mem_rdata};
                            end
                            dm_ack_q  <= 1'b1;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            state_q   <= DONE;
                        end
                    end
                end
                DM_HI: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            dm_rdata_q <= {mem_rdata, rd_lo_q};
                        end
                        dm_ack_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
